// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared types, counter encodings and width helpers for the fetch-group BPU
// Contents: br_type_e, fsm_state_e, btb_entry_t, CTR_* encodings,
//           grp_off/slot_w/idx_w width helpers, ctr_next saturating counter step.
package bpu_pkg;

  typedef enum logic [1:0] {
    BR_COND   = 2'd0,
    BR_DIRECT = 2'd1,
    BR_CALL   = 2'd2,
    BR_RETURN = 2'd3
  } br_type_e;

  typedef enum logic {
    ST_REFILL = 1'b0,
    ST_RUN    = 1'b1
  } fsm_state_e;

  // Entry fields are sized for the largest supported configuration; the top
  // zero-extends narrower tags/slots so unused upper bits stay constant.
  localparam int unsigned TAG_MAX_W  = 20;
  localparam int unsigned SLOT_MAX_W = 3;

  typedef struct packed {
    logic                  valid;
    logic [TAG_MAX_W-1:0]  tag;
    logic [SLOT_MAX_W-1:0] slot;
    logic [31:0]           target;
    br_type_e              btype;
  } btb_entry_t;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Byte offset width of one aligned fetch group.
  function automatic int unsigned grp_off(input int unsigned fw);
    return $clog2(fw) + 2;
  endfunction

  function automatic int unsigned slot_w(input int unsigned fw);
    return (fw > 1) ? $clog2(fw) : 1;
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == CTR_ST) ? c : c + 2'd1;
    else       return (c == CTR_SNT) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/bpu_fetch_group_if.sv
// rtl/bpu_fetch_group_if.sv - resolved-branch update bus from the backend
// Signals: upd_valid_i, upd_btb_i, upd_pc_i, upd_target_i, upd_type_i, upd_taken_i.
// Modports: master drives the update (backend), slave receives it (BPU).
interface bpu_fetch_group_if;
  logic                upd_valid_i;
  logic                upd_btb_i;
  logic [31:0]         upd_pc_i;
  logic [31:0]         upd_target_i;
  bpu_pkg::br_type_e   upd_type_i;
  logic                upd_taken_i;

  modport master (
    output upd_valid_i, upd_btb_i, upd_pc_i, upd_target_i, upd_type_i, upd_taken_i
  );
  modport slave (
    input  upd_valid_i, upd_btb_i, upd_pc_i, upd_target_i, upd_type_i, upd_taken_i
  );
endinterface

// File: rtl/bpu_ras.sv
// rtl/bpu_ras.sv - speculative return address stack with checkpoint restore
// Ports: clk, rst; push/push_data write at ptr+1 and advance; pop retreats;
//        restore/restore_ptr reload the pointer (wins over push/pop);
//        ptr is the current pointer, top the entry it addresses.
module bpu_ras
  import bpu_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [31:0]              push_data,
  input  logic                     restore,
  input  logic [idx_w(DEPTH)-1:0]  restore_ptr,
  output logic [idx_w(DEPTH)-1:0]  ptr,
  output logic [31:0]              top
);
  localparam int unsigned PW = idx_w(DEPTH);

  logic [31:0]   mem [2**PW];
  logic [PW-1:0] ptr_inc;

  assign ptr_inc = ptr + PW'(1);
  assign top     = mem[ptr];

  // Pointer wraps naturally; overflow overwrites the oldest entry.
  always_ff @(posedge clk) begin
    if (rst)          ptr <= '0;
    else if (restore) ptr <= restore_ptr;
    else if (push)    ptr <= ptr_inc;
    else if (pop)     ptr <= ptr - PW'(1);
  end

  // Contents survive a restore so the checkpointed pointer finds its data.
  always_ff @(posedge clk) begin
    if (push && !restore) mem[ptr_inc] <= push_data;
  end

endmodule

// File: rtl/bpu_fetch_group.sv
// rtl/bpu_fetch_group.sv - fetch-group PC generator with group BTB, 2-bit PHT and RAS
// Ports: clk, rst (sync, active-high); stall_i, flush_i/flush_target_i/flush_ras_ptr_i;
//        upd (resolved-branch update bus, slave);
//        pc_o, fetch_valid_o, valid_mask_o, pred_taken_o, pred_slot_o,
//        pred_target_o, pred_type_o, ras_ptr_o.
module bpu_fetch_group
  import bpu_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned BTB_ENTRIES = 64,
  parameter int unsigned BTB_TAG_W   = 10,
  parameter int unsigned PHT_ENTRIES = 256,
  parameter int unsigned RAS_DEPTH   = 8,
  parameter logic [31:0] RESET_PC    = 32'h1c00_0000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              stall_i,
  input  logic                              flush_i,
  input  logic [31:0]                       flush_target_i,
  input  logic [idx_w(RAS_DEPTH)-1:0]       flush_ras_ptr_i,
  bpu_fetch_group_if.slave                  upd,
  output logic [31:0]                       pc_o,
  output logic                              fetch_valid_o,
  output logic [FETCH_WIDTH-1:0]            valid_mask_o,
  output logic                              pred_taken_o,
  output logic [slot_w(FETCH_WIDTH)-1:0]    pred_slot_o,
  output logic [31:0]                       pred_target_o,
  output br_type_e                          pred_type_o,
  output logic [idx_w(RAS_DEPTH)-1:0]       ras_ptr_o
);
  localparam int unsigned OFF    = grp_off(FETCH_WIDTH);
  localparam int unsigned SW     = slot_w(FETCH_WIDTH);
  localparam int unsigned BTB_IW = idx_w(BTB_ENTRIES);
  localparam int unsigned PHT_IW = idx_w(PHT_ENTRIES);
  localparam int unsigned TAG_LO = OFF + BTB_IW;

  fsm_state_e state_q, state_n;
  logic [31:0] pc_q, pc_n;
  btb_entry_t  btb_q [BTB_ENTRIES];
  logic [1:0]  pht_q [PHT_ENTRIES];

  // Lookup side, all from the registered PC.
  logic [31:0]           base, seq_pc;
  logic [SLOT_MAX_W-1:0] s0, u_slot;
  logic [BTB_IW-1:0]     btb_idx, u_btb_idx;
  logic [PHT_IW-1:0]     pht_idx, u_pht_idx;
  logic [TAG_MAX_W-1:0]  tag, u_tag;
  btb_entry_t            ent;
  logic                  hit, taken, fire;
  logic [31:0]           pred_target, ras_top;
  logic                  ras_push, ras_pop;

  assign base    = {pc_q[31:OFF], {OFF{1'b0}}};
  assign seq_pc  = base + (32'(FETCH_WIDTH) << 2);
  assign btb_idx = pc_q[TAG_LO-1:OFF];
  assign tag     = TAG_MAX_W'(pc_q[TAG_LO+BTB_TAG_W-1 -: BTB_TAG_W]);
  assign pht_idx = pc_q[OFF+PHT_IW-1:OFF];

  assign u_btb_idx = upd.upd_pc_i[TAG_LO-1:OFF];
  assign u_tag     = TAG_MAX_W'(upd.upd_pc_i[TAG_LO+BTB_TAG_W-1 -: BTB_TAG_W]);
  assign u_pht_idx = upd.upd_pc_i[OFF+PHT_IW-1:OFF];

  // A one-instruction group has no slot bits in the PC.
  if (FETCH_WIDTH == 1) begin : g_slot1
    assign s0     = '0;
    assign u_slot = '0;
  end else begin : g_slotn
    assign s0     = SLOT_MAX_W'(pc_q[OFF-1:2]);
    assign u_slot = SLOT_MAX_W'(upd.upd_pc_i[OFF-1:2]);
  end

  assign ent = btb_q[btb_idx];
  // An entry whose branch sits before the entry slot of the group cannot fire.
  assign hit   = ent.valid && (ent.tag == tag) && (ent.slot >= s0);
  assign taken = hit && ((ent.btype != BR_COND) || pht_q[pht_idx][1]);

  always_comb begin
    pred_target = seq_pc;
    if (taken) pred_target = (ent.btype == BR_RETURN) ? ras_top : ent.target;
  end

  always_comb begin
    valid_mask_o = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      valid_mask_o[i] = (SLOT_MAX_W'(i) >= s0) && (!taken || SLOT_MAX_W'(i) <= ent.slot);
    end
  end

  // FSM and PC: flush beats stall, REFILL holds the PC for one cycle.
  always_comb begin
    state_n       = ST_RUN;
    fetch_valid_o = (state_q == ST_RUN);
    fire          = fetch_valid_o && !stall_i;
    pc_n          = pc_q;
    if (flush_i) begin
      state_n = ST_REFILL;
      pc_n    = flush_target_i;
    end else if (fire) begin
      pc_n = pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_REFILL;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
    end
  end

  // Updates are independent of stall/flush; lookups this cycle see old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb_q[i] <= '0;
    end else if (upd.upd_valid_i && upd.upd_btb_i) begin
      btb_q[u_btb_idx] <= '{valid:  1'b1,
                            tag:    u_tag,
                            slot:   u_slot,
                            target: upd.upd_target_i,
                            btype:  upd.upd_type_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= CTR_WNT;
    end else if (upd.upd_valid_i && upd.upd_type_i == BR_COND) begin
      pht_q[u_pht_idx] <= ctr_next(pht_q[u_pht_idx], upd.upd_taken_i);
    end
  end

  assign ras_push = fire && taken && (ent.btype == BR_CALL);
  assign ras_pop  = fire && taken && (ent.btype == BR_RETURN);

  bpu_ras #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk         (clk),
    .rst         (rst),
    .push        (ras_push),
    .pop         (ras_pop),
    .push_data   (base + ((32'(ent.slot) + 32'd1) << 2)),
    .restore     (flush_i),
    .restore_ptr (flush_ras_ptr_i),
    .ptr         (ras_ptr_o),
    .top         (ras_top)
  );

  assign pc_o          = pc_q;
  assign pred_taken_o  = taken;
  assign pred_slot_o   = ent.slot[SW-1:0];
  assign pred_target_o = pred_target;
  assign pred_type_o   = ent.btype;

  logic unused_upd_bits;
  assign unused_upd_bits = ^upd.upd_pc_i;

endmodule

// File: tb/tb_bpu_fetch_group.sv
// tb/tb_bpu_fetch_group.sv - scoreboard bench for bpu_fetch_group
module tb_bpu_fetch_group;
  import bpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall_i, flush_i;
  logic [31:0] flush_target_i;
  logic [2:0]  flush_ras_ptr_i;
  logic [31:0] pc_o, pred_target_o;
  logic        fetch_valid_o, pred_taken_o;
  logic [1:0]  valid_mask_o;
  logic [0:0]  pred_slot_o;
  br_type_e    pred_type_o;
  logic [2:0]  ras_ptr_o;

  always #5 clk = ~clk;

  bpu_fetch_group_if upd_bus ();

  bpu_fetch_group dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .flush_target_i  (flush_target_i),
    .flush_ras_ptr_i (flush_ras_ptr_i),
    .upd             (upd_bus),
    .pc_o            (pc_o),
    .fetch_valid_o   (fetch_valid_o),
    .valid_mask_o    (valid_mask_o),
    .pred_taken_o    (pred_taken_o),
    .pred_slot_o     (pred_slot_o),
    .pred_target_o   (pred_target_o),
    .pred_type_o     (pred_type_o),
    .ras_ptr_o       (ras_ptr_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  mask;
    logic        tk;
    logic        slot;
    br_type_e    typ;
    logic [31:0] tgt;
    logic [2:0]  rp;
  } grp_t;

  grp_t exp_q[$];
  grp_t g;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic exp_grp(input logic [31:0] pc, input logic [1:0] mask, input logic tk,
                         input logic slot, input br_type_e typ, input logic [31:0] tgt,
                         input logic [2:0] rp);
    exp_q.push_back('{pc: pc, mask: mask, tk: tk, slot: slot, typ: typ, tgt: tgt, rp: rp});
  endtask

  // Monitor: every fired group is popped and compared.
  always @(negedge clk) begin
    if (!rst && fetch_valid_o && !stall_i) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_group pc=%h expected no group", pc_o);
      end else begin
        g = exp_q.pop_front();
        chk("grp_pc", pc_o, g.pc);
        chk("grp_mask", 32'(valid_mask_o), 32'(g.mask));
        chk("grp_taken", 32'(pred_taken_o), 32'(g.tk));
        chk("grp_target", pred_target_o, g.tgt);
        chk("grp_ras_ptr", 32'(ras_ptr_o), 32'(g.rp));
        if (g.tk) begin
          chk("grp_slot", 32'(pred_slot_o), 32'(g.slot));
          chk("grp_type", 32'(pred_type_o), 32'(g.typ));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    flush_i             = 1'b0;
    upd_bus.upd_valid_i = 1'b0;
    upd_bus.upd_btb_i   = 1'b0;
  endtask

  task automatic upd(input logic btb, input logic [31:0] pc, input logic [31:0] tgt,
                     input br_type_e typ, input logic tk);
    upd_bus.upd_valid_i  = 1'b1;
    upd_bus.upd_btb_i    = btb;
    upd_bus.upd_pc_i     = pc;
    upd_bus.upd_target_i = tgt;
    upd_bus.upd_type_i   = typ;
    upd_bus.upd_taken_i  = tk;
  endtask

  task automatic flush_to(input logic [31:0] tgt, input logic [2:0] rp);
    flush_i         = 1'b1;
    flush_target_i  = tgt;
    flush_ras_ptr_i = rp;
  endtask

  task automatic hold();
    tick();
    stall_i = 1'b1;
  endtask

  // Flush while stalled, check the REFILL cycle, land in the first RUN cycle.
  task automatic refetch(input logic [31:0] tgt, input logic [2:0] rp);
    tick();
    flush_to(tgt, rp);
    tick();
    stall_i = 1'b0;
    chk("refill_valid", 32'(fetch_valid_o), 32'd0);
    chk("refill_pc", pc_o, tgt);
    chk("refill_ras_ptr", 32'(ras_ptr_o), 32'(rp));
    tick();
  endtask

  initial begin
    rst                  = 1'b1;
    stall_i              = 1'b0;
    flush_i              = 1'b0;
    flush_target_i       = '0;
    flush_ras_ptr_i      = '0;
    upd_bus.upd_valid_i  = 1'b0;
    upd_bus.upd_btb_i    = 1'b0;
    upd_bus.upd_pc_i     = '0;
    upd_bus.upd_target_i = '0;
    upd_bus.upd_type_i   = BR_COND;
    upd_bus.upd_taken_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state: one REFILL cycle at RESET_PC.
    chk("reset_pc", pc_o, 32'h1c00_0000);
    chk("reset_valid", 32'(fetch_valid_o), 32'd0);
    chk("reset_taken", 32'(pred_taken_o), 32'd0);
    chk("reset_mask", 32'(valid_mask_o), 32'h3);
    chk("reset_ras_ptr", 32'(ras_ptr_o), 32'd0);

    // Sequential groups.
    tick(); exp_grp(32'h1c00_0000, 2'b11, 1'b0, 1'b0, BR_COND, 32'h1c00_0008, 3'd0);
    tick(); exp_grp(32'h1c00_0008, 2'b11, 1'b0, 1'b0, BR_COND, 32'h1c00_0010, 3'd0);
    tick(); exp_grp(32'h1c00_0010, 2'b11, 1'b0, 1'b0, BR_COND, 32'h1c00_0018, 3'd0);

    // DIRECT branch in slot 1 of group 0x1c000000.
    hold();
    upd(1'b1, 32'h1c00_0004, 32'h1c00_0100, BR_DIRECT, 1'b1);
    tick();
    chk("stall_hold_pc", pc_o, 32'h1c00_0018);
    flush_to(32'h1c00_0000, 3'd0);
    tick();
    stall_i = 1'b0;
    chk("refill_valid", 32'(fetch_valid_o), 32'd0);
    tick(); exp_grp(32'h1c00_0000, 2'b11, 1'b1, 1'b1, BR_DIRECT, 32'h1c00_0100, 3'd0);
    tick(); exp_grp(32'h1c00_0100, 2'b11, 1'b0, 1'b0, BR_COND, 32'h1c00_0108, 3'd0);

    // Slot-0 entry must not hit when entering the group at slot 1.
    hold();
    upd(1'b1, 32'h1c00_0000, 32'h1c00_0300, BR_DIRECT, 1'b1);
    refetch(32'h1c00_0004, 3'd0);
    exp_grp(32'h1c00_0004, 2'b10, 1'b0, 1'b0, BR_COND, 32'h1c00_0008, 3'd0);

    // COND entry: install taken moves the reset counter 01 -> 10 (taken).
    hold();
    upd(1'b1, 32'h1c00_0004, 32'h1c00_0400, BR_COND, 1'b1);
    refetch(32'h1c00_0000, 3'd0);
    exp_grp(32'h1c00_0000, 2'b11, 1'b1, 1'b1, BR_COND, 32'h1c00_0400, 3'd0);
    // Three not-taken: 10 -> 01 -> 00 -> 00.
    hold();
    upd(1'b0, 32'h1c00_0004, 32'h0, BR_COND, 1'b0);
    tick(); upd(1'b0, 32'h1c00_0004, 32'h0, BR_COND, 1'b0);
    tick(); upd(1'b0, 32'h1c00_0004, 32'h0, BR_COND, 1'b0);
    refetch(32'h1c00_0000, 3'd0);
    exp_grp(32'h1c00_0000, 2'b11, 1'b0, 1'b0, BR_COND, 32'h1c00_0008, 3'd0);
    // One taken from saturated 00 gives 01: still not taken.
    hold();
    upd(1'b0, 32'h1c00_0004, 32'h0, BR_COND, 1'b1);
    refetch(32'h1c00_0000, 3'd0);
    exp_grp(32'h1c00_0000, 2'b11, 1'b0, 1'b0, BR_COND, 32'h1c00_0008, 3'd0);
    // Second taken gives 10: taken.
    hold();
    upd(1'b0, 32'h1c00_0004, 32'h0, BR_COND, 1'b1);
    refetch(32'h1c00_0000, 3'd0);
    exp_grp(32'h1c00_0000, 2'b11, 1'b1, 1'b1, BR_COND, 32'h1c00_0400, 3'd0);

    // CALL at slot 0, then RETURN at the aliasing group 0x1c000200,
    // written in the same cycle the CALL group is looked up.
    hold();
    upd(1'b1, 32'h1c00_0000, 32'h1c00_0200, BR_CALL, 1'b1);
    refetch(32'h1c00_0000, 3'd0);
    exp_grp(32'h1c00_0000, 2'b01, 1'b1, 1'b0, BR_CALL, 32'h1c00_0200, 3'd0);
    upd(1'b1, 32'h1c00_0200, 32'hdead_beec, BR_RETURN, 1'b1);
    tick(); exp_grp(32'h1c00_0200, 2'b01, 1'b1, 1'b0, BR_RETURN, 32'h1c00_0004, 3'd1);
    tick(); exp_grp(32'h1c00_0004, 2'b10, 1'b0, 1'b0, BR_COND, 32'h1c00_0008, 3'd0);
    hold();
    refetch(32'h1c00_0010, 3'd1);
    exp_grp(32'h1c00_0010, 2'b11, 1'b0, 1'b0, BR_COND, 32'h1c00_0018, 3'd1);

    // Three stall cycles with a flush in the middle one.
    hold();
    chk("stall1_pc", pc_o, 32'h1c00_0018);
    tick();
    chk("stall2_pc", pc_o, 32'h1c00_0018);
    chk("stall2_valid", 32'(fetch_valid_o), 32'd1);
    flush_to(32'h1c00_0030, 3'd1);
    tick();
    chk("stall3_pc", pc_o, 32'h1c00_0030);
    chk("stall3_refill", 32'(fetch_valid_o), 32'd0);
    tick();
    stall_i = 1'b0;
    exp_grp(32'h1c00_0030, 2'b11, 1'b0, 1'b0, BR_COND, 32'h1c00_0038, 3'd1);

    // Sequential next PC wraps at the top of the address space.
    hold();
    refetch(32'hffff_fff8, 3'd2);
    exp_grp(32'hffff_fff8, 2'b11, 1'b0, 1'b0, BR_COND, 32'h0000_0000, 3'd2);
    hold();
    tick();
    tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
